// File: rtl/icompress_pkg.sv
// Shared definitions for the streaming column compressor.
// Holds the default geometry, the derived widths, the FSM state type and
// the helper functions that grade one element (magnitude and shifted/saturated value).
package icompress_pkg;

  localparam int W_IN          = 128;
  localparam int LANES         = 8;
  localparam int SIZE_in_DATA  = 14;
  localparam int SIZE_val_DATA = 8;

  localparam int SIZE_col   = $clog2(W_IN);
  localparam int SIZE_count = $clog2(W_IN) + 1;
  localparam int SHIFT_W    = $clog2(SIZE_in_DATA);
  localparam int LANE_W     = $clog2(LANES);
  localparam int BEATS      = W_IN / LANES;
  localparam int BEAT_W     = $clog2(BEATS);
  // Wide enough for 1<<(2^SHIFT_W-1) and for a zero-extended magnitude.
  localparam int THR_W      = SIZE_in_DATA + 2;

  localparam logic [THR_W-1:0] THR_ONE = THR_W'(32'd1);
  localparam logic signed [SIZE_in_DATA-1:0] VAL_MAX =
    SIZE_in_DATA'((32'sd1 <<< (SIZE_val_DATA - 1)) - 32'sd1);
  localparam logic signed [SIZE_in_DATA-1:0] VAL_MIN =
    SIZE_in_DATA'(-(32'sd1 <<< (SIZE_val_DATA - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Arithmetic shift followed by saturation into the output value range.
  function automatic logic signed [SIZE_val_DATA-1:0] sat_shift(
    input logic signed [SIZE_in_DATA-1:0] x,
    input logic [SHIFT_W-1:0]             sh
  );
    logic signed [SIZE_in_DATA-1:0] s;
    s = x >>> sh;
    if (s > VAL_MAX) begin
      sat_shift = VAL_MAX[SIZE_val_DATA-1:0];
    end else if (s < VAL_MIN) begin
      sat_shift = VAL_MIN[SIZE_val_DATA-1:0];
    end else begin
      sat_shift = s[SIZE_val_DATA-1:0];
    end
  endfunction

  // Magnitude used for the threshold test. One extra bit keeps |min| exact.
  // In signed mode a negative element scores 0 and can never reach a
  // threshold, which is always at least 1.
  function automatic logic [SIZE_in_DATA:0] lane_mag(
    input logic signed [SIZE_in_DATA-1:0] x,
    input logic                           abs_mode
  );
    logic signed [SIZE_in_DATA:0] xe;
    xe = {x[SIZE_in_DATA-1], x};
    if (!xe[SIZE_in_DATA]) begin
      lane_mag = xe;
    end else if (abs_mode) begin
      lane_mag = -xe;
    end else begin
      lane_mag = {(SIZE_in_DATA+1){1'b0}};
    end
  endfunction

endpackage

// File: rtl/icompress_if.sv
// Stream bundle between column producer, compressor and sparse consumer.
//   in_valid/in_ready   : column + config handshake (producer -> compressor)
//   column_data, cfg_*  : the column and its shift/mode
//   out_valid/out_ready : result handshake (compressor -> consumer)
//   val, col, val_count : compacted values, indices and hit count
// master = producer/consumer side, slave = compressor.
interface icompress_if;
  import icompress_pkg::*;

  logic                            in_valid;
  logic                            in_ready;
  logic signed [SIZE_in_DATA-1:0]  column_data [W_IN];
  logic [SHIFT_W-1:0]              cfg_shift;
  logic                            cfg_abs_mode;
  logic                            out_valid;
  logic                            out_ready;
  logic signed [SIZE_val_DATA-1:0] val [W_IN];
  logic [SIZE_col-1:0]             col [W_IN];
  logic [SIZE_count-1:0]           val_count;

  modport master (
    output in_valid, column_data, cfg_shift, cfg_abs_mode, out_ready,
    input  in_ready, out_valid, val, col, val_count
  );

  modport slave (
    input  in_valid, column_data, cfg_shift, cfg_abs_mode, out_ready,
    output in_ready, out_valid, val, col, val_count
  );
endinterface

// File: rtl/icompress_lane_pack.sv
// Combinational grading of one beat of LANES elements.
//   elem     : the LANES elements of the current beat
//   shift    : shift amount; threshold = 1 << shift
//   abs_mode : 0 compares x, 1 compares |x|
//   hit      : per-lane threshold hit
//   offset   : per-lane slot offset (hits before this lane in the beat)
//   value    : per-lane shifted and saturated value
//   total    : number of hits in the beat
module icompress_lane_pack
  import icompress_pkg::*;
(
  input  logic signed [SIZE_in_DATA-1:0]  elem   [LANES],
  input  logic [SHIFT_W-1:0]              shift,
  input  logic                            abs_mode,
  output logic [LANES-1:0]                hit,
  output logic [LANE_W-1:0]               offset [LANES],
  output logic signed [SIZE_val_DATA-1:0] value  [LANES],
  output logic [LANE_W:0]                 total
);

  logic [THR_W-1:0]      thr_s;
  logic [SIZE_in_DATA:0] mag_s [LANES];
  logic [LANE_W:0]       run_s;

  // Per-lane hit/value with a running prefix count giving each hit its slot.
  always_comb begin
    thr_s = THR_ONE << shift;
    run_s = {(LANE_W+1){1'b0}};
    hit   = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      mag_s[i]  = lane_mag(elem[i], abs_mode);
      value[i]  = sat_shift(elem[i], shift);
      hit[i]    = ({1'b0, mag_s[i]} >= thr_s);
      // Lane i has at most i earlier hits, so the narrow slice is exact.
      offset[i] = run_s[LANE_W-1:0];
      run_s     = run_s + {{LANE_W{1'b0}}, hit[i]};
    end
    total = run_s;
  end

endmodule

// File: rtl/icompress_stream.sv
// Streaming column compressor: accepts one signed column, scans it LANES
// elements per beat and emits the compacted above-threshold values, their
// column indices and the hit count, held until the consumer takes them.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : icompress_if slave (input column/config, output result)
module icompress_stream
  import icompress_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  icompress_if.slave bus
);

  state_e                          state_r;
  logic [BEAT_W-1:0]               beat_r;
  logic [SIZE_count-1:0]           ptr_r;
  logic [SIZE_count-1:0]           count_r;
  logic                            in_ready_r;
  logic                            out_valid_r;
  logic [SHIFT_W-1:0]              shift_r;
  logic                            mode_r;
  logic signed [SIZE_in_DATA-1:0]  data_r [W_IN];
  logic signed [SIZE_val_DATA-1:0] val_r  [W_IN];
  logic [SIZE_col-1:0]             col_r  [W_IN];

  logic [SIZE_col-1:0]             lane_base_s;
  logic signed [SIZE_in_DATA-1:0]  lane_elem_s [LANES];
  logic [LANES-1:0]                hit_s;
  logic [LANE_W-1:0]               offset_s    [LANES];
  logic signed [SIZE_val_DATA-1:0] value_s     [LANES];
  logic [LANE_W:0]                 total_s;
  logic [SIZE_col-1:0]             slot_s      [LANES];
  logic [SIZE_col-1:0]             col_idx_s   [LANES];

  assign lane_base_s = {beat_r, {LANE_W{1'b0}}};

  // Select the current beat's elements and compute their target slots.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      col_idx_s[i]   = lane_base_s + SIZE_col'(i);
      lane_elem_s[i] = data_r[col_idx_s[i]];
      slot_s[i]      = ptr_r[SIZE_col-1:0] + SIZE_col'(offset_s[i]);
    end
  end

  icompress_lane_pack u_lane_pack (
    .elem     (lane_elem_s),
    .shift    (shift_r),
    .abs_mode (mode_r),
    .hit      (hit_s),
    .offset   (offset_s),
    .value    (value_s),
    .total    (total_s)
  );

  // Control FSM with the beat counter, write pointer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      beat_r      <= {BEAT_W{1'b0}};
      ptr_r       <= {SIZE_count{1'b0}};
      count_r     <= {SIZE_count{1'b0}};
      shift_r     <= {SHIFT_W{1'b0}};
      mode_r      <= 1'b0;
      for (int j = 0; j < W_IN; j++) begin
        data_r[j] <= {SIZE_in_DATA{1'b0}};
        val_r[j]  <= {SIZE_val_DATA{1'b0}};
        col_r[j]  <= {SIZE_col{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            state_r    <= SCAN;
            in_ready_r <= 1'b0;
            data_r     <= bus.column_data;
            shift_r    <= bus.cfg_shift;
            mode_r     <= bus.cfg_abs_mode;
            beat_r     <= {BEAT_W{1'b0}};
            ptr_r      <= {SIZE_count{1'b0}};
            count_r    <= {SIZE_count{1'b0}};
            for (int j = 0; j < W_IN; j++) begin
              val_r[j] <= {SIZE_val_DATA{1'b0}};
              col_r[j] <= {SIZE_col{1'b0}};
            end
          end
        end
        SCAN: begin
          for (int i = 0; i < LANES; i++) begin
            if (hit_s[i]) begin
              val_r[slot_s[i]] <= value_s[i];
              col_r[slot_s[i]] <= col_idx_s[i];
            end
          end
          ptr_r  <= ptr_r + SIZE_count'(total_s);
          beat_r <= beat_r + BEAT_W'(1'b1);
          if (beat_r == BEAT_W'(BEATS - 32'sd1)) begin
            state_r <= DONE;
            // An all-hit column lands exactly on W_IN; the count is wide enough.
            count_r <= ptr_r + SIZE_count'(total_s);
          end
        end
        DONE: begin
          // One settle cycle after the final beat before the result is offered.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.val       = val_r;
  assign bus.col       = col_r;
  assign bus.val_count = count_r;

endmodule
